// File: rtl/urv_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// urv_dmem_responder_if
// Data-memory request/response bundle between the execute/writeback stages
// (master) and the on-chip data memory (slave).
//   dm_addr         byte address of the access
//   dm_data_s       store data, already replicated per lane
//   dm_data_select  byte-lane enables, bit n covers bits [8n+7:8n]
//   dm_load         load request pulse
//   dm_store        store request pulse
//   dm_ready        responder can accept a request this cycle
//   dm_data_l       full-word load data
//   dm_load_done    one-cycle pulse, dm_data_l valid
//   dm_store_done   one-cycle pulse, store committed
//   dm_error        one-cycle pulse: out-of-range access or protocol violation
// -----------------------------------------------------------------------------
interface urv_dmem_responder_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_s;
  logic [3:0]  dm_data_select;
  logic        dm_load;
  logic        dm_store;
  logic        dm_ready;
  logic [31:0] dm_data_l;
  logic        dm_load_done;
  logic        dm_store_done;
  logic        dm_error;

  modport master (
    output dm_addr, dm_data_s, dm_data_select, dm_load, dm_store,
    input  dm_ready, dm_data_l, dm_load_done, dm_store_done, dm_error
  );

  modport slave (
    input  dm_addr, dm_data_s, dm_data_select, dm_load, dm_store,
    output dm_ready, dm_data_l, dm_load_done, dm_store_done, dm_error
  );
endinterface

// File: rtl/urv_dmem_responder.sv
// -----------------------------------------------------------------------------
// urv_dmem_responder
// Single-port on-chip data memory serving the core's data-memory interface.
// Accepts single-cycle load/store pulses, writes only the selected byte lanes,
// and returns full-word load data after g_wait_states extra cycles. Ready is
// registered and drops while a multi-cycle access is in flight.
//   clk_i    clock, all logic on the rising edge
//   rst_n_i  synchronous active-low reset
//   dm       urv_dmem_responder_if.slave request/response bundle
// Parameters:
//   g_addr_width   word-address bits (2^g_addr_width words of 32 bits)
//   g_wait_states  extra cycles per access, 0..7
// -----------------------------------------------------------------------------
module urv_dmem_responder #(
  parameter int g_addr_width  = 10,
  parameter int g_wait_states = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  urv_dmem_responder_if.slave    dm
);

  localparam int c_depth = 1 << g_addr_width;

  localparam logic [1:0] RESET_HOLD = 2'd0;
  localparam logic [1:0] IDLE       = 2'd1;
  localparam logic [1:0] WAIT       = 2'd2;

  // Counter preload on entering WAIT; unused when there are no wait states.
  localparam logic [2:0] c_cnt_init = (g_wait_states == 0) ? 3'd0 : 3'(g_wait_states - 1);

  logic [1:0]  state_q;
  logic [2:0]  cnt_q;
  logic        ready_q;
  logic [31:0] data_l_q;
  logic        load_done_q;
  logic        store_done_q;
  logic        error_q;

  // Request captured at accept time, used by the commit edge when W>0.
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  sel_q;
  logic        store_q;

  logic        accept;
  logic        violation;
  logic        commit;
  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic [3:0]  c_sel;
  logic        c_store;
  logic        in_range;
  logic [g_addr_width-1:0] word_idx;

  logic [31:0] mem [c_depth];

  // Ready is a register, so acceptance never feeds back into ready within a cycle.
  assign accept    = ready_q & (dm.dm_load ^ dm.dm_store);
  assign violation = ready_q & dm.dm_load & dm.dm_store;

  // With no wait states the access commits on the accept edge itself, so the
  // live request is used; otherwise the captured copy commits at the end of WAIT.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    commit  = 1'b0;
    c_addr  = addr_q;
    c_data  = data_q;
    c_sel   = sel_q;
    c_store = store_q;
    if (g_wait_states == 0) begin
      commit  = accept;
      c_addr  = dm.dm_addr;
      c_data  = dm.dm_data_s;
      c_sel   = dm.dm_data_select;
      c_store = dm.dm_store;
    end else begin
      commit  = (state_q == WAIT) && (cnt_q == 3'd0);
    end
  end

  assign in_range = (c_addr >> (g_addr_width + 2)) == 32'd0;
  assign word_idx = c_addr[g_addr_width+1:2];

  // NOTE: the storage array has no reset; its contents survive reset by design.
  // Writes are still gated by rst_n_i so that a reset on the commit edge aborts them.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && commit && c_store && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) mem[word_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= RESET_HOLD;
      cnt_q        <= 3'd0;
      ready_q      <= 1'b0;
      data_l_q     <= 32'd0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      load_done_q  <= commit & ~c_store;
      store_done_q <= commit & c_store;
      error_q      <= (commit & ~in_range) | violation;

      if (commit && !c_store) data_l_q <= in_range ? mem[word_idx] : 32'd0;

      if (accept) begin
        addr_q  <= dm.dm_addr;
        data_q  <= dm.dm_data_s;
        sel_q   <= dm.dm_data_select;
        store_q <= dm.dm_store;
      end

      case (state_q)
        RESET_HOLD: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        IDLE: begin
          if (accept && g_wait_states != 0) begin
            state_q <= WAIT;
            cnt_q   <= c_cnt_init;
            ready_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign dm.dm_ready      = ready_q;
  assign dm.dm_data_l     = data_l_q;
  assign dm.dm_load_done  = load_done_q;
  assign dm.dm_store_done = store_done_q;
  assign dm.dm_error      = error_q;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_urv_dmem_responder
// Directed bench for urv_dmem_responder. Three instances share one clock and
// reset: u0 (no wait states), u3 (three wait states) and u2 (two wait states).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so each step lands in the next clock cycle.
// -----------------------------------------------------------------------------
module tb_urv_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  urv_dmem_responder_if if0 ();
  urv_dmem_responder_if if3 ();
  urv_dmem_responder_if if2 ();

  urv_dmem_responder #(.g_addr_width(10), .g_wait_states(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .dm(if0)
  );
  urv_dmem_responder #(.g_addr_width(10), .g_wait_states(3)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .dm(if3)
  );
  urv_dmem_responder #(.g_addr_width(10), .g_wait_states(2)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .dm(if2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic ld, input logic st, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    if0.dm_load = ld; if0.dm_store = st; if0.dm_addr = a;
    if0.dm_data_s = d; if0.dm_data_select = s;
  endtask

  task automatic req3(input logic ld, input logic st, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    if3.dm_load = ld; if3.dm_store = st; if3.dm_addr = a;
    if3.dm_data_s = d; if3.dm_data_select = s;
  endtask

  task automatic req2(input logic ld, input logic st, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    if2.dm_load = ld; if2.dm_store = st; if2.dm_addr = a;
    if2.dm_data_s = d; if2.dm_data_select = s;
  endtask

  initial begin
    req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    req3(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    req2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset values
    rst_n = 1'b0;
    step(); step();
    check1 ("rst_ready0",     if0.dm_ready,      1'b0);
    check32("rst_data_l0",    if0.dm_data_l,     32'h0);
    check1 ("rst_ld_done0",   if0.dm_load_done,  1'b0);
    check1 ("rst_st_done0",   if0.dm_store_done, 1'b0);
    check1 ("rst_err0",       if0.dm_error,      1'b0);
    check1 ("rst_ready3",     if3.dm_ready,      1'b0);
    rst_n = 1'b1;
    step();
    check1 ("rel_ready0",     if0.dm_ready,      1'b1);
    check1 ("rel_ready3",     if3.dm_ready,      1'b1);

    // W=0: store then back-to-back load of the same word
    req0(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    check1 ("w0_st_done",     if0.dm_store_done, 1'b1);
    check1 ("w0_ready_c1",    if0.dm_ready,      1'b1);
    req0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step();
    check1 ("w0_ld_done",     if0.dm_load_done,  1'b1);
    check32("w0_ld_data",     if0.dm_data_l,     32'hDEADBEEF);
    check1 ("w0_st_done_off", if0.dm_store_done, 1'b0);
    check1 ("w0_ready_c2",    if0.dm_ready,      1'b1);

    // Byte lanes: lane 2 only
    req0(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    step();
    req0(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'b0100);
    step();
    req0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    step();
    check32("lane2_data",     if0.dm_data_l,     32'h11AA3344);
    // Empty select still completes but changes nothing
    req0(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    step();
    req0(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'b0000);
    step();
    check1 ("sel0_st_done",   if0.dm_store_done, 1'b1);
    req0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    step();
    check32("sel0_data",      if0.dm_data_l,     32'h11223344);

    // Out-of-range store and load (0x1000 aliases word 0 if bounds are ignored)
    req0(1'b0, 1'b1, 32'h0, 32'h01020304, 4'hF);
    step();
    req0(1'b0, 1'b1, 32'h1000, 32'h55555555, 4'hF);
    step();
    check1 ("oor_st_done",    if0.dm_store_done, 1'b1);
    check1 ("oor_st_err",     if0.dm_error,      1'b1);
    req0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check32("oor_mem_intact", if0.dm_data_l,     32'h01020304);
    check1 ("oor_no_err",     if0.dm_error,      1'b0);
    req0(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    step();
    check1 ("oor_ld_done",    if0.dm_load_done,  1'b1);
    check32("oor_ld_data",    if0.dm_data_l,     32'h0);
    check1 ("oor_ld_err",     if0.dm_error,      1'b1);
    req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check1 ("oor_err_clear",  if0.dm_error,      1'b0);

    // Protocol violation: load and store together
    req0(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF);
    step();
    req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check1 ("pv_err",         if0.dm_error,      1'b1);
    check1 ("pv_no_ld_done",  if0.dm_load_done,  1'b0);
    check1 ("pv_no_st_done",  if0.dm_store_done, 1'b0);
    check1 ("pv_ready",       if0.dm_ready,      1'b1);
    step();
    check1 ("pv_err_once",    if0.dm_error,      1'b0);
    req0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check32("pv_mem_intact",  if0.dm_data_l,     32'h01020304);

    // W=3: preload two words
    req3(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    step();
    req3(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(); step(); step();
    check1 ("w3_st_done",     if3.dm_store_done, 1'b1);
    check1 ("w3_st_ready",    if3.dm_ready,      1'b1);
    req3(1'b0, 1'b1, 32'h44, 32'h12345678, 4'hF);
    step();
    req3(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(); step(); step();
    check1 ("w3_st2_ready",   if3.dm_ready,      1'b1);

    // W=3: load, with a second request held through the busy window
    req3(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    step();
    check1 ("w3_ready_c1",    if3.dm_ready,      1'b0);
    req3(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    step();
    check1 ("w3_ready_c2",    if3.dm_ready,      1'b0);
    check1 ("w3_no_done_c2",  if3.dm_load_done,  1'b0);
    step();
    check1 ("w3_ready_c3",    if3.dm_ready,      1'b0);
    step();
    check1 ("w3_ld_done_c4",  if3.dm_load_done,  1'b1);
    check1 ("w3_ready_c4",    if3.dm_ready,      1'b1);
    check32("w3_ld_data_c4",  if3.dm_data_l,     32'hCAFEF00D);
    step();
    req3(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check1 ("w3_held_accept", if3.dm_ready,      1'b0);
    check1 ("w3_done_off",    if3.dm_load_done,  1'b0);
    check32("w3_data_hold",   if3.dm_data_l,     32'hCAFEF00D);
    step(); step(); step();
    check1 ("w3_ld2_done",    if3.dm_load_done,  1'b1);
    check32("w3_ld2_data",    if3.dm_data_l,     32'h12345678);
    step();
    check1 ("w3_no_dup_done", if3.dm_load_done,  1'b0);
    check1 ("w3_idle_ready",  if3.dm_ready,      1'b1);

    // W=2: reset on the commit edge aborts a pending store
    req2(1'b0, 1'b1, 32'h80, 32'h0BADC0DE, 4'hF);
    step();
    req2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(); step();
    check1 ("w2_pre_done",    if2.dm_store_done, 1'b1);
    req2(1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);
    step();
    req2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check1 ("w2_ready_c1",    if2.dm_ready,      1'b0);
    step();
    rst_n = 1'b0;
    step();
    check1 ("w2_rst_ready",   if2.dm_ready,      1'b0);
    check1 ("w2_rst_no_done", if2.dm_store_done, 1'b0);
    check1 ("w2_rst_no_err",  if2.dm_error,      1'b0);
    rst_n = 1'b1;
    step();
    check1 ("w2_rel_ready",   if2.dm_ready,      1'b1);
    check1 ("w2_rel_no_done", if2.dm_store_done, 1'b0);
    req2(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    step();
    req2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(); step();
    check1 ("w2_ld_done",     if2.dm_load_done,  1'b1);
    check32("w2_old_value",   if2.dm_data_l,     32'h0BADC0DE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/urv_dmem_responder.md
# urv_dmem_responder

Single-port on-chip data memory that serves the core's data-memory request interface. It accepts the single-cycle load/store pulses issued by the execute stage, applies byte-lane write enables, and returns full-word load data to the writeback stage after a configurable number of wait states. It deasserts ready while an access is in flight, so the execute stage stalls.

## Interface

Parameters:
- g_addr_width, default 10: word-address bits; memory holds 2^g_addr_width 32-bit words.
- g_wait_states, default 0: extra cycles per access, legal range 0..7.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  reset; one clock domain, synchronous, active-low
- dm_addr_i  in  32  byte address of the access
- dm_data_s_i  in  32  store data, already replicated per lane by initiator
- dm_data_select_i  in  4  byte-lane enables; bit n = bits [8n+7:8n]
- dm_load_i  in  1  load request pulse, valid only when dm_ready_o=1
- dm_store_i  in  1  store request pulse, valid only when dm_ready_o=1
- dm_ready_o  out  1  responder can accept a request this cycle
- dm_data_l_o  out  32  full-word load data; lane extraction is done by writeback
- dm_load_done_o  out  1  one-cycle pulse, dm_data_l_o valid
- dm_store_done_o  out  1  one-cycle pulse, store committed
- dm_error_o  out  1  one-cycle pulse with the done pulse: out-of-range address or protocol violation

## Operation

- States: RESET_HOLD, IDLE, WAIT.
- Accept happens when dm_ready_o=1 and exactly one of dm_load_i or dm_store_i is high. On accept, latch the address, data, select and op type.
- Word index is dm_addr_i[g_addr_width+1:2]. Address bits [1:0] are ignored for indexing.
- Out of range means dm_addr_i[31:g_addr_width+2] != 0. For an out-of-range access, no write occurs and a load returns 32'h0. dm_error_o pulses with the done pulse.
- Store: only the bytes with their select bit set are written. Select 4'b0000 leaves memory unchanged but still produces dm_store_done_o.
- Load: returns the whole addressed word.
- dm_load_i and dm_store_i both high while ready is a protocol violation:
  - No access is performed and no done pulse is produced.
  - dm_error_o pulses in the following cycle.
  - Ready behaves as if nothing was accepted.
- A request while dm_ready_o=0 is ignored silently.
- Memory contents are not initialized or cleared by reset.

## Timing

- Reset values (while rst_n_i=0): dm_ready_o=0, dm_data_l_o=0, all done/error pulses 0, state RESET_HOLD, wait counter 0. The cycle after release: state IDLE, dm_ready_o=1.
- Let cycle 0 be the accept cycle and W = g_wait_states.
- The memory read or write commits on the rising edge ending cycle W.
- dm_load_done_o or dm_store_done_o (and dm_error_o if applicable) is high in cycle W+1 only.
- dm_data_l_o is updated in cycle W+1 and holds until the next load completes.
- W=0:
  - dm_ready_o stays 1, giving a sustained throughput of one access per cycle.
  - A load in cycle 1 to the word stored in cycle 0 returns the new data.
- W>0:
  - dm_ready_o is a registered output: it goes 0 in cycle 1 and stays 0 through cycle W.
  - It returns to 1 in cycle W+1, coincident with the done pulse, so a new request may be accepted in cycle W+1.
  - The counter loads W-1 on entering WAIT, decrements each cycle, and returns to IDLE when it reaches 0.
- Reset mid-access: if rst_n_i=0 at any edge up to and including the commit edge, the pending access is aborted. No write occurs, no done or error pulse is produced, and the normal reset values apply.
- dm_ready_o never depends combinationally on request inputs.

## Test plan

- Reset then W=0: store 0xDEADBEEF, select 4'b1111, addr 0x10 in cycle 0; load addr 0x10 in cycle 1 -> dm_store_done_o in cycle 1, dm_load_done_o in cycle 2 with dm_data_l_o=0xDEADBEEF, dm_ready_o constantly 1.
- Byte lanes: word 0x20 holds 0x11223344; store data 0xAAAAAAAA, select 4'b0100 -> subsequent load returns 0x11AA3344. Select 4'b0000 -> load returns 0x11223344, store done still pulses.
- W=3: load accepted in cycle 0 -> dm_ready_o=0 in cycles 1..3, dm_load_done_o and dm_ready_o=1 in cycle 4. A second request held during cycles 1..3 is ignored; when held in cycle 4 it is accepted.
- Out-of-range, g_addr_width=10, addr 0x00001000: store -> memory unchanged, dm_store_done_o and dm_error_o in the same cycle. Load -> dm_data_l_o=0 with dm_error_o.
- Both dm_load_i and dm_store_i high in cycle 0 -> no done pulse, dm_error_o in cycle 1 only, memory unchanged.
- W=2: store accepted in cycle 0, rst_n_i=0 during cycle 2 (the commit edge) -> no done pulse, dm_ready_o=0 during reset and 1 the cycle after release, and a later load of that word shows the old value.
